// File: rtl/overlay_sched.sv
// Overlay mode scheduler: arbitrates host and debounced button mode changes, times the show window.
// Optional SHOW timeout to IDLE is enabled by defining OVERLAY_SCHED_AUTOHIDE_EN.
module overlay_sched #(
    parameter int unsigned MODES    = 8,
    parameter int unsigned DEB_CNT  = 1000000,
    parameter int unsigned COOL_CNT = 1000,
    parameter int unsigned SHOW_CNT = 200000000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     btn_i,
    input  logic                     host_req_i,
    input  logic [$clog2(MODES)-1:0] host_mode_i,
    output logic                     host_ack_o,
    output logic [$clog2(MODES)-1:0] mode_o,
    output logic                     show_o,
    output logic                     busy_o
);
    localparam int unsigned MW = $clog2(MODES);

    typedef enum logic [1:0] {IDLE, COOL, SHOW} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [MW-1:0] mode_q, mode_d;
    logic [MW-1:0] host_mode_c;
    logic [1:0]    sync_q;
    logic          deb_q, deb_prev_q;
    logic [31:0]   deb_cnt_q;
    logic          btn_pend_q;
    logic          host_take, btn_take, can_accept;
    logic          ack_q, busy_q, show_q;

    if (COOL_CNT == 0 || SHOW_CNT == 0) begin : g_param_check
        $error("overlay_sched: COOL_CNT and SHOW_CNT must be at least 1");
    end

    // Only a non-power-of-two mode count can see out-of-range host requests.
    if ((2 ** MW) > MODES) begin : g_clamp
        assign host_mode_c = (host_mode_i > MW'(MODES - 1)) ? MW'(MODES - 1) : host_mode_i;
    end else begin : g_noclamp
        assign host_mode_c = host_mode_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            btn_pend_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            deb_prev_q <= deb_q;
            if (sync_q[1] != deb_q) begin
                if (deb_cnt_q == DEB_CNT - 1) begin
                    deb_q     <= sync_q[1];
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 32'd1;
                end
            end else begin
                deb_cnt_q <= '0;
            end
            // A new rising edge wins over a same-cycle service so it is not lost.
            btn_pend_q <= (btn_pend_q & ~btn_take) | (deb_q & ~deb_prev_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        host_take  = 1'b0;
        btn_take   = 1'b0;
        can_accept = (state_q != COOL);
        if (can_accept && host_req_i) begin
            host_take = 1'b1;
            mode_d    = host_mode_c;
        end else if (can_accept && btn_pend_q) begin
            btn_take = 1'b1;
            mode_d   = (mode_q == MW'(MODES - 1)) ? '0 : mode_q + 1'b1;
        end
        if (host_take || btn_take) begin
            state_d = COOL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                COOL: begin
                    if (cnt_q == COOL_CNT - 1) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
`ifdef OVERLAY_SCHED_AUTOHIDE_EN
                SHOW: begin
                    if (cnt_q == SHOW_CNT - 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            mode_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            show_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ack_q   <= host_take;
            busy_q  <= (state_d == COOL);
            show_q  <= (state_d != IDLE);
        end
    end

    assign host_ack_o = ack_q;
    assign mode_o     = mode_q;
    assign busy_o     = busy_q;
    assign show_o     = show_q;
endmodule

// File: tb/tb_overlay_sched.sv
// Directed self-checking bench for overlay_sched (MODES=8, DEB_CNT=4, COOL_CNT=3, SHOW_CNT=10).
// Expectations follow OVERLAY_SCHED_AUTOHIDE_EN when it is defined for the build.
module tb_overlay_sched;
`ifdef OVERLAY_SCHED_AUTOHIDE_EN
    localparam bit AUTOHIDE = 1'b1;
`else
    localparam bit AUTOHIDE = 1'b0;
`endif
    localparam logic IDLE_SHOW = AUTOHIDE ? 1'b0 : 1'b1;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       btn_i;
    logic       host_req_i;
    logic [2:0] host_mode_i;
    logic       host_ack_o;
    logic [2:0] mode_o;
    logic       show_o;
    logic       busy_o;

    int tests = 0;
    int failed = 0;
    logic [2:0] exp_mode;

    overlay_sched #(
        .MODES   (8),
        .DEB_CNT (4),
        .COOL_CNT(3),
        .SHOW_CNT(10)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .btn_i      (btn_i),
        .host_req_i (host_req_i),
        .host_mode_i(host_mode_i),
        .host_ack_o (host_ack_o),
        .mode_o     (mode_o),
        .show_o     (show_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, mode_o, 0);
        check({tag, "_show"}, show_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ack"}, host_ack_o, 0);
    endtask

    // Called at the sample point right after an accepting edge.
    task automatic window(input logic [2:0] m);
        for (int i = 0; i < 13; i++) begin
            check("win_mode", mode_o, m);
            check("win_show", show_o, 1);
            check("win_busy", busy_o, (i < 3) ? 1 : 0);
            check("win_ack", host_ack_o, (i == 0) ? 1 : 0);
            @(negedge clk_i);
        end
        check("win_end_show", show_o, IDLE_SHOW);
    endtask

    // Bounce 1-0-1, then hold high; leaves btn_i low before the 8th edge.
    task automatic press_head();
        logic [6:0] pat;
        pat = 7'b1111101;
        for (int k = 0; k < 7; k++) begin
            btn_i = pat[k];
            @(negedge clk_i);
        end
        btn_i = 1'b0;
    endtask

    task automatic press();
        press_head();
        repeat (10) @(negedge clk_i);
    endtask

    initial begin
        rst_ni      = 1'b0;
        btn_i       = 1'b0;
        host_req_i  = 1'b0;
        host_mode_i = 3'd0;
        repeat (3) @(negedge clk_i);
        check_reset_vals("rst");

        // Power-up window: SHOW for SHOW_CNT cycles.
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("pwr_show", show_o, 1);
            check("pwr_ack", host_ack_o, 0);
            check("pwr_mode", mode_o, 0);
            @(negedge clk_i);
        end
        check("pwr_end_show", show_o, IDLE_SHOW);

        // Button presses: one increment each, wrapping 7 -> 0.
        exp_mode = 3'd0;
        for (int p = 0; p < 8; p++) begin
            press();
            exp_mode = (exp_mode == 3'd7) ? 3'd0 : exp_mode + 3'd1;
            check("btn_mode", mode_o, exp_mode);
            check("btn_busy", busy_o, 0);
        end
        repeat (10) @(negedge clk_i);
        check("idle_show", show_o, IDLE_SHOW);

        // Host request from IDLE.
        host_req_i  = 1'b1;
        host_mode_i = 3'd5;
        @(negedge clk_i);
        host_req_i = 1'b0;
        window(3'd5);

        // Host and pending button on the same edge: host first, button after COOL.
        press_head();
        repeat (2) @(negedge clk_i);
        host_req_i  = 1'b1;
        host_mode_i = 3'd2;
        @(negedge clk_i);
        check("sim_mode", mode_o, 2);
        check("sim_ack", host_ack_o, 1);
        check("sim_busy", busy_o, 1);
        host_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("sim_cool_mode", mode_o, 2);
        check("sim_cool_busy", busy_o, 0);
        @(negedge clk_i);
        check("sim_btn_mode", mode_o, 3);
        check("sim_btn_ack", host_ack_o, 0);
        check("sim_btn_busy", busy_o, 1);
        repeat (10) @(negedge clk_i);

        // Held request: no re-ack in COOL, re-accepted (same mode) at COOL exit.
        host_req_i  = 1'b1;
        host_mode_i = 3'd6;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            check("hold_ack", host_ack_o, (i == 0) ? 1 : 0);
            check("hold_busy", busy_o, (i < 3) ? 1 : 0);
            check("hold_mode", mode_o, 6);
            @(negedge clk_i);
        end
        host_req_i = 1'b0;
        window(3'd6);

        // Reset mid-SHOW with a held request that is served after release.
        host_req_i  = 1'b1;
        host_mode_i = 3'd4;
        @(negedge clk_i);
        check("pre_rst_mode", mode_o, 4);
        check("pre_rst_ack", host_ack_o, 1);
        host_req_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("pre_rst_busy", busy_o, 0);
        host_req_i  = 1'b1;
        host_mode_i = 3'd3;
        rst_ni      = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk_i);
        check_reset_vals("held_rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        host_req_i = 1'b0;
        window(3'd3);
        repeat (30) @(negedge clk_i);
        check("late_show", show_o, IDLE_SHOW);
        check("late_mode", mode_o, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
